// File: rtl/cpu_pkg.sv
// Shared datapath constants, ALU opcode encoding and flag bit positions.
// Used by the execution datapath and by the instruction controller FSM.
package cpu_pkg;

    localparam int DATA_W = 16;
    localparam int RF_AW  = 4;
    localparam int DM_AW  = 8;

    typedef enum logic [2:0] {
        ADD   = 3'b000,
        SUB   = 3'b001,
        AND   = 3'b010,
        OR    = 3'b011,
        XOR   = 3'b100,
        NOTA  = 3'b101,
        PASSA = 3'b110,
        PASSB = 3'b111
    } alu_op_e;

    // Flags are packed {N,Z,C}
    localparam int FLAG_N = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_C = 0;

endpackage

// File: rtl/register_file.sv
// Purpose: 2-read/1-write register file, all registers cleared by synchronous reset.
// Latency: reads combinational; a write becomes visible on the read ports the cycle after the edge.
// Backpressure: none, a write is accepted on every edge where we is high.
module register_file #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int RF_AW  = cpu_pkg::RF_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [RF_AW-1:0]  w_addr,
    input  logic [DATA_W-1:0] w_dat,
    input  logic [RF_AW-1:0]  ra_addr,
    input  logic [RF_AW-1:0]  rb_addr,
    output logic [DATA_W-1:0] ra_dat,
    output logic [DATA_W-1:0] rb_dat
);

    logic [DATA_W-1:0] regs [2**RF_AW];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2**RF_AW; i++) begin
                regs[i] <= '0;
            end
        end else if (we) begin
            regs[w_addr] <= w_dat;
        end
    end

    // No write-through bypass: same-cycle reads see the old contents
    assign ra_dat = regs[ra_addr];
    assign rb_dat = regs[rb_addr];

endmodule

// File: rtl/cpu_datapath.sv
// Purpose: execution stage with register file, ALU, data memory, flag register and write-back mux.
// Latency: RF reads and ALU combinational; Mem_q and Flags registered (1 cycle).
// Backpressure: none, controls are consumed every cycle and the controller sequences loads itself.
module cpu_datapath #(
    parameter int DATA_W = cpu_pkg::DATA_W,
    parameter int RF_AW  = cpu_pkg::RF_AW,
    parameter int DM_AW  = cpu_pkg::DM_AW
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [DM_AW-1:0]  D_addr,
    input  logic              D_wr,
    input  logic              RF_s,
    input  logic              RF_W_en,
    input  logic [RF_AW-1:0]  RF_W_addr,
    input  logic [RF_AW-1:0]  RF_Ra_addr,
    input  logic [RF_AW-1:0]  RF_Rb_addr,
    input  logic [2:0]        ALU_s0,
    output logic [DATA_W-1:0] Ra_data,
    output logic [DATA_W-1:0] Rb_data,
    output logic [DATA_W-1:0] ALU_out,
    output logic [DATA_W-1:0] Mem_q,
    output logic [2:0]        Flags
);

    import cpu_pkg::*;

    logic [DATA_W:0]   alu_wide;
    logic              alu_c;
    logic [DATA_W-1:0] wb_dat;
    logic [DATA_W-1:0] mem [2**DM_AW];

    register_file #(
        .DATA_W (DATA_W),
        .RF_AW  (RF_AW)
    ) u_rf (
        .clk     (Clock),
        .rst     (Reset),
        .we      (RF_W_en),
        .w_addr  (RF_W_addr),
        .w_dat   (wb_dat),
        .ra_addr (RF_Ra_addr),
        .rb_addr (RF_Rb_addr),
        .ra_dat  (Ra_data),
        .rb_dat  (Rb_data)
    );

    always_comb begin
        alu_wide = '0;
        alu_c    = 1'b0;
        ALU_out  = '0;
        case (alu_op_e'(ALU_s0))
            ADD: begin
                alu_wide = {1'b0, Ra_data} + {1'b0, Rb_data};
                ALU_out  = alu_wide[DATA_W-1:0];
                alu_c    = alu_wide[DATA_W];
            end
            SUB: begin
                // Borrow shows up in the extra bit; C is its inverse (A >= B unsigned)
                alu_wide = {1'b0, Ra_data} - {1'b0, Rb_data};
                ALU_out  = alu_wide[DATA_W-1:0];
                alu_c    = ~alu_wide[DATA_W];
            end
            AND:     ALU_out = Ra_data & Rb_data;
            OR:      ALU_out = Ra_data | Rb_data;
            XOR:     ALU_out = Ra_data ^ Rb_data;
            NOTA:    ALU_out = ~Ra_data;
            PASSA:   ALU_out = Ra_data;
            PASSB:   ALU_out = Rb_data;
            default: ALU_out = '0;
        endcase
    end

    assign wb_dat = RF_s ? Mem_q : ALU_out;

    // Only ALU write-backs touch the flags; loads and idle cycles hold them
    always_ff @(posedge Clock) begin
        if (Reset) begin
            Flags <= '0;
        end else if (RF_W_en && !RF_s) begin
            Flags[FLAG_N] <= ALU_out[DATA_W-1];
            Flags[FLAG_Z] <= (ALU_out == '0);
            Flags[FLAG_C] <= alu_c;
        end
    end

    // Memory array has no reset so it can map onto RAM; reset only blocks the store
    always_ff @(posedge Clock) begin
        if (D_wr && !Reset) begin
            mem[D_addr] <= Ra_data;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            Mem_q <= '0;
        end else begin
            Mem_q <= mem[D_addr];
        end
    end

    assert property (@(posedge Clock) !$isunknown({RF_W_en, D_wr}));

endmodule

// File: tb/tb_cpu_datapath.sv
// Bench for cpu_datapath: directed scenarios plus a random instruction stream against a reference model.
module tb_cpu_datapath;

    localparam int OP_ADD = 0, OP_SUB = 1, OP_XOR = 4, OP_NOTA = 5, OP_PASSB = 7;
    localparam int ONE_REG = 15;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  d_addr;
    logic        d_wr, rf_s, rf_w_en;
    logic [3:0]  rf_w_addr, rf_ra_addr, rf_rb_addr;
    logic [2:0]  alu_s0;
    logic [15:0] ra_data, rb_data, alu_out, mem_q;
    logic [2:0]  flags;

    int n_cmp = 0;
    int n_bad = 0;

    logic [15:0] m_rf [16];
    logic [15:0] m_mem [256];
    bit          m_mem_ok [256];
    logic [15:0] m_memq;
    bit          m_memq_ok;
    logic [2:0]  m_flags;

    always #5 clk = ~clk;

    cpu_datapath dut (
        .Clock      (clk),
        .Reset      (reset),
        .D_addr     (d_addr),
        .D_wr       (d_wr),
        .RF_s       (rf_s),
        .RF_W_en    (rf_w_en),
        .RF_W_addr  (rf_w_addr),
        .RF_Ra_addr (rf_ra_addr),
        .RF_Rb_addr (rf_rb_addr),
        .ALU_s0     (alu_s0),
        .Ra_data    (ra_data),
        .Rb_data    (rb_data),
        .ALU_out    (alu_out),
        .Mem_q      (mem_q),
        .Flags      (flags)
    );

    function automatic void ref_alu(input int op, input int a, input int b, output int r, output int c);
        r = 0;
        c = 0;
        case (op)
            0: begin r = (a + b) % 65536; c = (a + b > 65535) ? 1 : 0; end
            1: begin r = (a - b + 65536) % 65536; c = (a >= b) ? 1 : 0; end
            2: r = a & b;
            3: r = a | b;
            4: r = a ^ b;
            5: r = 65535 - a;
            6: r = a;
            7: r = b;
            default: r = 0;
        endcase
    endfunction

    // Advance the model with the current inputs, then let the DUT take the same edge
    task automatic step();
        int a, b, r, c;
        logic [15:0] wb;
        a = int'(m_rf[rf_ra_addr]);
        b = int'(m_rf[rf_rb_addr]);
        ref_alu(int'(alu_s0), a, b, r, c);
        if (reset) begin
            for (int i = 0; i < 16; i++) m_rf[i] = '0;
            m_memq    = '0;
            m_memq_ok = 1'b1;
            m_flags   = '0;
        end else begin
            wb        = rf_s ? m_memq : 16'(r);
            m_memq    = m_mem[d_addr];
            m_memq_ok = m_mem_ok[d_addr];
            if (d_wr) begin
                m_mem[d_addr]    = 16'(a);
                m_mem_ok[d_addr] = 1'b1;
            end
            if (rf_w_en) begin
                m_rf[rf_w_addr] = wb;
                if (!rf_s) m_flags = {r >= 32768, r == 0, c != 0};
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rf_w_en = 1'b0;
        d_wr    = 1'b0;
        rf_s    = 1'b0;
    endtask

    task automatic set_op(input int w, input int a, input int b, input int op);
        rf_w_en    = 1'b1;
        rf_s       = 1'b0;
        d_wr       = 1'b0;
        rf_w_addr  = 4'(w);
        rf_ra_addr = 4'(a);
        rf_rb_addr = 4'(b);
        alu_s0     = 3'(op);
    endtask

    task automatic op(input int w, input int a, input int b, input int code);
        set_op(w, a, b, code);
        step();
    endtask

    // R15 = 1, built from whatever R14 holds
    task automatic init_one();
        op(14, 14, 14, OP_XOR);
        op(ONE_REG, 14, 14, OP_NOTA);
        op(14, ONE_REG, ONE_REG, OP_ADD);
        op(ONE_REG, ONE_REG, 14, OP_XOR);
    endtask

    // Shift-and-add a constant into register t using R15 = 1
    task automatic load_const(input int t, input logic [15:0] v);
        op(t, t, t, OP_XOR);
        for (int i = 15; i >= 0; i--) begin
            op(t, t, t, OP_ADD);
            if (v[i]) op(t, t, ONE_REG, OP_ADD);
        end
    endtask

    task automatic store(input int src, input logic [7:0] addr);
        idle();
        d_wr       = 1'b1;
        d_addr     = addr;
        rf_ra_addr = 4'(src);
        step();
        idle();
    endtask

    task automatic test_reset();
        reset = 1'b1; idle(); d_addr = 8'h00; alu_s0 = 3'd0;
        rf_w_addr = 4'd0; rf_ra_addr = 4'd0; rf_rb_addr = 4'd0;
        step();
        reset = 1'b0;
        init_one();
        load_const(1, 16'hA5A5);
        load_const(2, 16'h5A5A);
        store(1, 8'h10);
        op(3, ONE_REG, ONE_REG, OP_SUB);
        n_cmp++;
        if (flags !== 3'b011) begin n_bad++; $display("FAIL reset_preflags got %b want 011", flags); end
        reset = 1'b1; rf_w_en = 1'b1; rf_w_addr = 4'd3; d_wr = 1'b1; d_addr = 8'h10; rf_ra_addr = 4'd2;
        step();
        reset = 1'b0; idle();
        n_cmp++;
        if (flags !== 3'b000) begin n_bad++; $display("FAIL reset_flags got %b want 000", flags); end
        n_cmp++;
        if (mem_q !== 16'h0000) begin n_bad++; $display("FAIL reset_memq got %h want 0000", mem_q); end
        for (int i = 0; i < 16; i++) begin
            rf_ra_addr = 4'(i);
            step();
            n_cmp++;
            if (ra_data !== 16'h0000) begin n_bad++; $display("FAIL reset_reg%0d got %h want 0000", i, ra_data); end
        end
        n_cmp++;
        if (mem_q !== 16'hA5A5) begin n_bad++; $display("FAIL reset_mem_kept got %h want a5a5", mem_q); end
    endtask

    task automatic test_alu();
        init_one();
        load_const(1, 16'h7FFF);
        load_const(2, 16'h0001);
        set_op(3, 1, 2, OP_ADD); #1;
        n_cmp++;
        if (alu_out !== 16'h8000) begin n_bad++; $display("FAIL alu_add_ovf got %h want 8000", alu_out); end
        step();
        n_cmp++;
        if (flags !== 3'b100) begin n_bad++; $display("FAIL alu_add_ovf_flags got %b want 100", flags); end
        idle(); rf_ra_addr = 4'd3; #1;
        n_cmp++;
        if (ra_data !== 16'h8000) begin n_bad++; $display("FAIL alu_r3 got %h want 8000", ra_data); end
        set_op(4, 2, 2, OP_SUB); #1;
        n_cmp++;
        if (alu_out !== 16'h0000) begin n_bad++; $display("FAIL alu_sub_self got %h want 0000", alu_out); end
        step();
        n_cmp++;
        if (flags !== 3'b011) begin n_bad++; $display("FAIL alu_sub_flags got %b want 011", flags); end
        load_const(5, 16'hFFFF);
        set_op(6, 5, 2, OP_ADD); #1;
        n_cmp++;
        if (alu_out !== 16'h0000) begin n_bad++; $display("FAIL alu_add_wrap got %h want 0000", alu_out); end
        step();
        n_cmp++;
        if (flags !== 3'b011) begin n_bad++; $display("FAIL alu_add_wrap_flags got %b want 011", flags); end
    endtask

    task automatic test_store_load();
        logic [2:0] exp_flags;
        load_const(4, 16'hBEEF);
        store(4, 8'h2A);
        exp_flags = m_flags;
        d_addr = 8'h2A;
        step();
        n_cmp++;
        if (mem_q !== 16'hBEEF) begin n_bad++; $display("FAIL load_memq got %h want beef", mem_q); end
        rf_w_en = 1'b1; rf_s = 1'b1; rf_w_addr = 4'd5;
        rf_ra_addr = 4'd0; rf_rb_addr = 4'd0; alu_s0 = 3'(OP_ADD);
        step();
        idle(); rf_ra_addr = 4'd5; #1;
        n_cmp++;
        if (ra_data !== 16'hBEEF) begin n_bad++; $display("FAIL load_r5 got %h want beef", ra_data); end
        n_cmp++;
        if (flags !== exp_flags) begin n_bad++; $display("FAIL load_flags_held got %b want %b", flags, exp_flags); end
    endtask

    task automatic test_hazards();
        load_const(6, 16'h0F0F);
        load_const(7, 16'h1234);
        set_op(6, 6, 7, OP_PASSB); #1;
        n_cmp++;
        if (ra_data !== 16'h0F0F) begin n_bad++; $display("FAIL haz_rf_old got %h want 0f0f", ra_data); end
        step();
        n_cmp++;
        if (ra_data !== 16'h1234) begin n_bad++; $display("FAIL haz_rf_new got %h want 1234", ra_data); end
        store(6, 8'h33);
        load_const(8, 16'hABCD);
        idle(); d_wr = 1'b1; d_addr = 8'h33; rf_ra_addr = 4'd8;
        step();
        n_cmp++;
        if (mem_q !== 16'h1234) begin n_bad++; $display("FAIL haz_mem_old got %h want 1234", mem_q); end
        idle();
        step();
        n_cmp++;
        if (mem_q !== 16'hABCD) begin n_bad++; $display("FAIL haz_mem_new got %h want abcd", mem_q); end
    endtask

    task automatic test_wrap_random();
        int r, c;
        load_const(9, 16'hC3C3);
        store(9, 8'hFF);
        d_addr = 8'hFF;
        step();
        n_cmp++;
        if (mem_q !== 16'hC3C3) begin n_bad++; $display("FAIL wrap_memq got %h want c3c3", mem_q); end
        rf_w_en = 1'b1; rf_s = 1'b1; rf_w_addr = 4'd10;
        step();
        idle(); rf_ra_addr = 4'd10; #1;
        n_cmp++;
        if (ra_data !== 16'hC3C3) begin n_bad++; $display("FAIL wrap_r10 got %h want c3c3", ra_data); end
        for (int k = 1; k <= 13; k++) load_const(k, 16'($urandom_range(0, 65535)));
        for (int i = 0; i < 1000; i++) begin
            rf_ra_addr = 4'($urandom % 16);
            rf_rb_addr = 4'($urandom % 16);
            rf_w_addr  = 4'($urandom % 16);
            alu_s0     = 3'(i % 8);
            rf_w_en    = ($urandom % 4) != 0;
            rf_s       = m_memq_ok && (($urandom % 4) == 0);
            d_wr       = ($urandom % 8) == 0;
            case ($urandom % 5)
                0: d_addr = 8'h00;
                1: d_addr = 8'hFF;
                2: d_addr = 8'h2A;
                3: d_addr = 8'h33;
                default: d_addr = 8'($urandom);
            endcase
            #1;
            ref_alu(i % 8, int'(m_rf[rf_ra_addr]), int'(m_rf[rf_rb_addr]), r, c);
            n_cmp++;
            if (alu_out !== 16'(r)) begin n_bad++; $display("FAIL rand_alu op%0d got %h want %h", i % 8, alu_out, 16'(r)); end
            n_cmp++;
            if (ra_data !== m_rf[rf_ra_addr]) begin n_bad++; $display("FAIL rand_ra got %h want %h", ra_data, m_rf[rf_ra_addr]); end
            step();
            n_cmp++;
            if (flags !== m_flags) begin n_bad++; $display("FAIL rand_flags op%0d got %b want %b", i % 8, flags, m_flags); end
            if (m_memq_ok) begin
                n_cmp++;
                if (mem_q !== m_memq) begin n_bad++; $display("FAIL rand_memq got %h want %h", mem_q, m_memq); end
            end
        end
        idle();
    endtask

    task automatic test_reset_mid_load();
        init_one();
        load_const(12, 16'h6E6E);
        load_const(11, 16'h1357);
        store(12, 8'h80);
        d_addr = 8'h80;
        step();
        n_cmp++;
        if (mem_q !== 16'h6E6E) begin n_bad++; $display("FAIL midload_memq got %h want 6e6e", mem_q); end
        reset = 1'b1; rf_w_en = 1'b1; rf_s = 1'b1; rf_w_addr = 4'd11;
        step();
        reset = 1'b0; idle(); rf_ra_addr = 4'd11; #1;
        n_cmp++;
        if (ra_data !== 16'h0000) begin n_bad++; $display("FAIL midload_dest got %h want 0000", ra_data); end
        n_cmp++;
        if (mem_q !== 16'h0000) begin n_bad++; $display("FAIL midload_memq_rst got %h want 0000", mem_q); end
        n_cmp++;
        if (flags !== 3'b000) begin n_bad++; $display("FAIL midload_flags got %b want 000", flags); end
    endtask

    initial begin
        reset = 1'b1; d_addr = '0; d_wr = 1'b0; rf_s = 1'b0; rf_w_en = 1'b0;
        rf_w_addr = '0; rf_ra_addr = '0; rf_rb_addr = '0; alu_s0 = '0;
        test_reset();
        test_alu();
        test_store_load();
        test_hazards();
        test_wrap_random();
        test_reset_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
